// File: rtl/vga_pkg.sv
// Shared display definitions: default timing, pattern modes, Wishbone constants.
package vga_pkg;

    localparam int HDISP_DEFAULT = 800;
    localparam int VDISP_DEFAULT = 480;

    typedef enum logic [1:0] {
        GRID  = 2'd0,
        BARS  = 2'd1,
        GRAD  = 2'd2,
        SOLID = 2'd3
    } mire_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } mire_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    function automatic logic [31:0] pack_rgb(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return {8'h00, r, g, b};
    endfunction

endpackage

// File: rtl/mire_pattern.sv
// Combinational test-pattern generator: (mode, x, y) -> {8'h00,R,G,B}.
module mire_pattern import vga_pkg::*; #(
    parameter int HDISP = HDISP_DEFAULT,
    parameter int XW    = $clog2(HDISP),
    parameter int YW    = $clog2(VDISP_DEFAULT)
) (
    input  mire_mode_e      mode,
    input  logic [XW-1:0]   x,
    input  logic [YW-1:0]   y,
    output logic [31:0]     pixel
);

    // Bar width is at least one pixel so tiny test frames still show bars.
    localparam int BAR_W = (HDISP / 8 > 0) ? HDISP / 8 : 1;

    logic [15:0] x_ext;
    logic [15:0] y_ext;
    logic [15:0] bar;
    logic [2:0]  bar_idx;

    assign x_ext = 16'(x);
    assign y_ext = 16'(y);

    // Select the pixel colour for the current mode and position.
    always_comb begin
        bar     = x_ext / 16'(BAR_W);
        bar_idx = (bar > 16'd7) ? 3'd7 : bar[2:0];
        pixel   = 32'h0;
        case (mode)
            GRID:    pixel = (x_ext[3:0] == 4'd0 || y_ext[3:0] == 4'd0)
                             ? pack_rgb(8'hFF, 8'hFF, 8'hFF) : 32'h0;
            BARS:    pixel = pack_rgb({8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}});
            GRAD:    pixel = pack_rgb(x_ext[7:0], y_ext[7:0], x_ext[7:0] ^ y_ext[7:0]);
            default: pixel = pack_rgb(8'h00, 8'h00, 8'hFF);
        endcase
    end

endmodule

// File: rtl/mire_writer.sv
// Wishbone B4 classic master painting one test-pattern frame into the framebuffer.
// Handshake: a write is presented while cyc=stb=1 and completes on the clock edge
// where ack=1; adr/dat_ms hold until that edge. err/rty without ack simply leave
// the write pending, so the same word is re-presented. After BURST_LEN acks the
// bus is released for PAUSE_CYCLES cycles to let the display reader in.
module mire_writer import vga_pkg::*; #(
    parameter int          HDISP        = HDISP_DEFAULT,
    parameter int          VDISP        = VDISP_DEFAULT,
    parameter logic [31:0] BASE_ADR     = 32'h0,
    parameter int          BURST_LEN    = 64,
    parameter int          PAUSE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    input  logic [31:0] dat_sm,
    output logic        we,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    output logic        cyc,
    output logic        stb,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output mire_state_e fsm_state
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int PW = $clog2(PAUSE_CYCLES + 1);

    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PAUSE_CYCLES - 1);

    mire_state_e   state_q, state_d;
    mire_mode_e    mode_q, mode_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [PW-1:0] pause_q, pause_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q;
    logic [31:0]   pixel_d;
    logic          load;

    // Read data is never needed; err/rty behave exactly like a missing ack.
    logic unused_inputs;
    assign unused_inputs = ^{dat_sm, err, rty};

    mire_pattern #(
        .HDISP (HDISP),
        .XW    (XW),
        .YW    (YW)
    ) u_pattern (
        .mode  (mode_d),
        .x     (x_d),
        .y     (y_d),
        .pixel (pixel_d)
    );

    // State, position, address and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= GRID;
            x_q     <= '0;
            y_q     <= '0;
            burst_q <= '0;
            pause_q <= '0;
            adr_q   <= BASE_ADR;
            dat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            burst_q <= burst_d;
            pause_q <= pause_d;
            adr_q   <= adr_d;
            if (load) dat_q <= pixel_d;
        end
    end

    // Next-state logic: frame start, pixel advance on ack, burst pauses.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        burst_d = burst_q;
        pause_d = pause_q;
        adr_d   = adr_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mire_mode_e'(mode);
                    x_d     = '0;
                    y_d     = '0;
                    burst_d = '0;
                    adr_d   = BASE_ADR;
                    load    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ack) begin
                    load    = 1'b1;
                    adr_d   = adr_q + 32'd4;
                    burst_d = burst_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    // Frame end wins over burst end.
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        state_d = ST_DONE;
                    end else if (burst_q == B_LAST) begin
                        pause_d = '0;
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                burst_d = '0;
                if (pause_q == P_LAST) state_d = ST_WRITE;
                else                   pause_d = pause_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cyc       = (state_q == ST_WRITE);
    assign stb       = cyc;
    assign we        = cyc;
    assign sel       = 4'b1111;
    assign cti       = CTI_CLASSIC;
    assign bte       = BTE_LINEAR;
    assign busy      = (state_q == ST_WRITE) || (state_q == ST_PAUSE);
    assign done      = (state_q == ST_DONE);
    assign adr       = adr_q;
    assign dat_ms    = dat_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mire_writer.sv
// Bench for mire_writer: small 8x4 frame with a reactive slave, plus a default-size instance.
module tb_mire_writer;
    import vga_pkg::*;

    localparam int          H    = 8;
    localparam int          V    = 4;
    localparam int          BL   = 4;
    localparam int          PC   = 2;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          NPIX = H * V;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- small DUT ----------------
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [31:0] dat_sm = 32'h0;
    logic        busy, done, we, cyc, stb;
    logic [31:0] adr, dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    mire_state_e fsm_state;

    mire_writer #(.HDISP(H), .VDISP(V), .BASE_ADR(BASE), .BURST_LEN(BL), .PAUSE_CYCLES(PC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
        .adr(adr), .dat_ms(dat_ms), .dat_sm(dat_sm), .we(we), .sel(sel), .cti(cti), .bte(bte),
        .cyc(cyc), .stb(stb), .ack(ack), .err(err), .rty(rty), .fsm_state(fsm_state)
    );

    // ---------------- default-size DUT ----------------
    logic        d_start = 1'b0;
    logic [1:0]  d_mode = 2'd0;
    logic        d_ack;
    logic [31:0] d_dat_sm = 32'h0;
    logic        d_busy, d_done, d_we, d_cyc, d_stb;
    logic [31:0] d_adr, d_dat_ms;
    logic [3:0]  d_sel;
    logic [2:0]  d_cti;
    logic [1:0]  d_bte;
    mire_state_e d_fsm_state;

    assign d_ack = d_cyc & d_stb;

    mire_writer d_dut (
        .clk(clk), .rst_n(rst_n), .start(d_start), .mode(d_mode), .busy(d_busy), .done(d_done),
        .adr(d_adr), .dat_ms(d_dat_ms), .dat_sm(d_dat_sm), .we(d_we), .sel(d_sel), .cti(d_cti),
        .bte(d_bte), .cyc(d_cyc), .stb(d_stb), .ack(d_ack), .err(1'b0), .rty(1'b0),
        .fsm_state(d_fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mem[NPIX];
    logic [31:0] golden[NPIX];
    int          acks, wait_left, max_wait, err_pix, rty_pix, both_pix;
    bit          err_done, rty_done, hold_chk, in_gap;
    logic [31:0] held_adr, held_dat;
    int          gap, gap_cnt, done_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference pixel straight from the pattern rules.
    function automatic logic [31:0] ref_pixel(input int m, input int x, input int y, input int h);
        int i;
        case (m)
            0: return ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FFFFFF : 32'h0;
            1: begin
                i = x / (h / 8);
                if (i > 7) i = 7;
                return {8'h00, ((i & 4) != 0) ? 8'hFF : 8'h00,
                               ((i & 2) != 0) ? 8'hFF : 8'h00,
                               ((i & 1) != 0) ? 8'hFF : 8'h00};
            end
            2: return {8'h00, 8'(x % 256), 8'(y % 256), 8'((x ^ y) % 256)};
            default: return 32'h000000FF;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic prep(input int m, input int mw, input int ep, input int rp, input int bp);
        logic [31:0] a;
        exp_q.delete();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                a = BASE + 32'(4 * (y * H + x));
                exp_q.push_back({a, ref_pixel(m, x, y, H)});
            end
        for (int i = 0; i < NPIX; i++) mem[i] = 32'hDEADBEEF;
        acks = 0; wait_left = 0; max_wait = mw;
        err_pix = ep; rty_pix = rp; both_pix = bp;
        err_done = 0; rty_done = 0; hold_chk = 0;
        in_gap = 0; gap = 0; gap_cnt = 0; done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt > 0), 1);
        repeat (4) @(negedge clk);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    task automatic check_frame(input int m, input string tag);
        check({tag, "_pending"}, exp_q.size(), 0);
        for (int i = 0; i < NPIX; i++)
            check({tag, "_mem"}, mem[i], ref_pixel(m, i % H, i / H, H));
    endtask

    // ---------------- slave model ----------------
    initial begin
        logic [63:0] e;
        int idx;
        forever begin
            @(negedge clk);
            ack = 1'b0; err = 1'b0; rty = 1'b0;
            if (!rst_n) begin
                in_gap = 0;
                hold_chk = 0;
            end else begin
                if (in_gap) begin
                    if (cyc) begin
                        check("pause_len", gap, PC);
                        in_gap = 0;
                    end else begin
                        gap++;
                        check("stb_in_pause", stb, 0);
                    end
                end
                if (cyc && stb) begin
                    if (hold_chk) begin
                        check("hold_adr", adr, held_adr);
                        check("hold_dat", dat_ms, held_dat);
                        hold_chk = 0;
                    end
                    if (acks == err_pix && !err_done) begin
                        err = 1'b1; err_done = 1; hold_chk = 1;
                        held_adr = adr; held_dat = dat_ms;
                    end else if (acks == rty_pix && !rty_done) begin
                        rty = 1'b1; rty_done = 1; hold_chk = 1;
                        held_adr = adr; held_dat = dat_ms;
                    end else if (wait_left > 0) begin
                        wait_left--;
                    end else begin
                        ack = 1'b1;
                        if (acks == both_pix) rty = 1'b1;
                        check("we", we, 1);
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                        check("write", {adr, dat_ms}, e);
                        idx = int'((adr - BASE) >> 2);
                        if (idx >= 0 && idx < NPIX) mem[idx] = dat_ms;
                        acks++;
                        wait_left = $urandom_range(0, max_wait);
                        if (acks % BL == 0 && acks < NPIX) begin
                            in_gap = 1; gap = 0; gap_cnt++;
                        end
                    end
                end
            end
        end
    end

    // done pulse monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
            end
        end
    end

    // ---------------- scenarios ----------------
    initial begin
        int n;
        int d_idx;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cyc", cyc, 0);
        check("rst_stb", stb, 0);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_adr", adr, BASE);
        check("rst_dat", dat_ms, 0);
        check("rst_state", fsm_state, ST_IDLE);
        rst_n = 1'b1;

        // GRAD frame, ack every cycle, bus released after every 4th ack
        prep(2, 0, -1, -1, -1);
        pulse_start(2'd2);
        wait_done("s1");
        check_frame(2, "s1");
        check("s1_pix_3_2", mem[2 * H + 3], 32'h00030201);
        check("s1_bursts", gap_cnt, 7);
        for (int i = 0; i < NPIX; i++) golden[i] = mem[i];

        // GRID frame, same throttling
        prep(0, 0, -1, -1, -1);
        pulse_start(2'd0);
        wait_done("s2");
        check_frame(0, "s2");
        check("s2_bursts", gap_cnt, 7);

        // Random wait states, err on pixel 5, rty on pixel 9, ack+rty on pixel 20
        prep(2, 3, 5, 9, 20);
        pulse_start(2'd2);
        wait_done("s3");
        check_frame(2, "s3");
        for (int i = 0; i < NPIX; i++) check("s3_vs_s1", mem[i], golden[i]);

        // Start pulses and mode changes while busy
        prep(1, 1, -1, -1, -1);
        pulse_start(2'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) begin
                start = 1'($urandom_range(0, 1));
                mode = 2'($urandom);
            end else begin
                start = 1'b0;
            end
        end while (busy && n < 2000);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("s4_done_once", done_cnt, 1);
        check("s4_busy_low", busy, 0);
        check_frame(1, "s4");

        // Asynchronous reset in the middle of pixel 13
        prep(3, 2, -1, -1, -1);
        pulse_start(2'd3);
        n = 0;
        while (acks < 13 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("s5_reach", 64'(acks >= 13), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("s5_cyc", cyc, 0);
        check("s5_stb", stb, 0);
        check("s5_busy", busy, 0);
        check("s5_adr", adr, BASE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("s5_no_done", done_cnt, 0);
        prep(3, 1, -1, -1, -1);
        pulse_start(2'd3);
        wait_done("s5");
        check_frame(3, "s5");

        // Default geometry, BARS, first line and start of second
        @(negedge clk);
        d_mode = 2'd1;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        d_idx = 0;
        n = 0;
        while (d_idx <= 800 && n < 3000) begin
            if (d_cyc && d_stb) begin
                if (d_idx == 99 || d_idx == 100 || d_idx == 200 || d_idx == 799 || d_idx == 800) begin
                    check("d_adr", d_adr, 32'(4 * d_idx));
                    check("d_pix", d_dat_ms, ref_pixel(1, d_idx % 800, d_idx / 800, 800));
                end
                d_idx++;
            end
            @(negedge clk);
            n++;
        end
        check("d_reach", 64'(d_idx > 800), 1);
        check("d_busy", d_busy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
